muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multiply/divide unit with its own HI/LO registers and sequencing FSM; serves MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the Execute stage.
- Generates the decode-stage stall request consumed by the hazard unit.
- Replaces the single-step multiply path; MFHI/MFLO results reach writeback through the existing multiply-result mux.

Parameters:
- XLEN, 32, operand/HI/LO width
- STEPS, 32, iteration count per operation (must equal XLEN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- startE  in  1  mul/div instruction in Execute, sampled each edge
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca2E  in  XLEN  forwarded rs operand (multiplicand/dividend)
- srcb2E  in  XLEN  forwarded rt operand (multiplier/divisor)
- mthiE  in  1  write srca2E to HI
- mtloE  in  1  write srca2E to LO
- hiloD  in  1  Decode holds MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
- stallMD  out  1  stall request to hazard unit
- busy  out  1  operation in progress
- done  out  1  final cycle of an operation
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, stallMD=0; any in-flight operation is abandoned with no HI/LO update.
- States: IDLE, RUN, FIX.
  - IDLE→RUN on an edge with startE=1. Latch opE, |srca2E|, |srcb2E| (abs only for signed ops), sign flags; step counter=0.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter increments; after STEPS RUN cycles go to FIX.
  - FIX: apply sign correction, assert done=1, load hi/lo on the closing edge, go to IDLE.
- Latency: start sampled at edge k; RUN occupies cycles k..k+31, FIX cycle k+32; new hi/lo visible after edge k+33. busy=1 in RUN and FIX (33 cycles).
- Results:
  - Multiply: {hi,lo} = 64-bit product. Signed: negate if operand signs differ.
  - Divide: lo = quotient, hi = remainder. Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: full latency, hi = dividend (original value), lo = all ones.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stallMD = hiloD & (busy | startE). The hazard unit freezes F/D and flushes E, so no HI/LO-touching instruction reaches Execute during an operation.
- Ignored inputs:
  - startE while busy: ignored (defensive).
  - mthiE/mtloE while busy: ignored.
  - mthiE/mtloE in IDLE: write next edge; both may assert together.
  - mthiE/mtloE with startE: start wins, move ignored.
- done is combinational from state==FIX; hi/lo change only on the FIX closing edge or on an MTHI/MTLO write.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU, RUN exits to FIX as soon as the remaining unshifted multiplier bits are all zero. Each elided step shifts the partial product in one cycle, so the result is identical. Minimum total busy = 2 cycles (multiplier 0). Divide is unchanged.
- Undefined: fixed 33-cycle busy for every operation.

Decomposition:
- Package muldiv_pkg:
  - op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state enum (IDLE, RUN, FIX)
  - STEPS_DEFAULT=32
  - DIV0_LO constant (all ones)
- Sub-module muldiv_step: combinational single iteration. Inputs: mode, accumulator, shift register, operand. Outputs: next accumulator/shift register. Controller holds FSM, counter, sign fixup, HI/LO.

Test Plan:
- Reset mid-RUN (cycle 10 of MULT 7×9) → hi=lo=0, busy=0 immediately; no later update.
- MULT 0xFFFFFFFD × 5 → after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands → hi=0x4, lo=0xFFFFFFF1; done high exactly cycle k+32.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x1234 / 0 → hi=0x1234, lo=0xFFFFFFFF after full latency; DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- hiloD=1 throughout an op → stallMD=1 from the start cycle through FIX, 0 the cycle after; startE pulse mid-RUN → ignored, result unchanged.
- MTHI 0xAAAA and MTLO 0x5555 same cycle in IDLE → hi=0xAAAA, lo=0x5555 next edge. With MULDIV_EARLY_OUT_EN: MULTU 3×2 → busy ≤4 cycles, lo=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int STEPS_DEFAULT = 32;
  localparam int XLEN_DEFAULT  = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // LO value produced by a divide with a zero divisor
  localparam logic [XLEN_DEFAULT-1:0] DIV0_LO = '1;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute/Decode-side bundle of the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);

  // startE is a single-cycle request taken only while busy=0; there is no
  // ready, busy=1 means every further start or HI/LO move is dropped.
  logic            startE;
  logic [1:0]      opE;
  logic [XLEN-1:0] srca2E;
  logic [XLEN-1:0] srcb2E;
  logic            mthiE;
  logic            mtloE;
  logic            hiloD;
  logic            stallMD;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output startE, opE, srca2E, srcb2E, mthiE, mtloE, hiloD,
    input  stallMD, busy, done, hi, lo
  );

  modport slave (
    input  startE, opE, srca2E, srcb2E, mthiE, mtloE, hiloD,
    output stallMD, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational shift-add (multiply) or restoring shift-subtract (divide) iteration.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_sreg,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_sreg
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_sreg[0] ? {1'b0, i_opnd} : '0);
        w_shifted = {i_acc, i_sreg[XLEN-1]};
        w_diff    = w_shifted - {1'b0, i_opnd};
        if (i_is_div) begin
            // Top bit of the difference is the borrow: set means restore
            if (w_diff[XLEN]) begin
                o_acc  = w_shifted[XLEN-1:0];
                o_sreg = {i_sreg[XLEN-2:0], 1'b0};
            end else begin
                o_acc  = w_diff[XLEN-1:0];
                o_sreg = {i_sreg[XLEN-2:0], 1'b1};
            end
        end else begin
            o_acc  = w_sum[XLEN:1];
            o_sreg = {w_sum[0], i_sreg[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, step counter, sign fixup, HI/LO registers.
// Optional MULT/MULTU early exit enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int STEPS = STEPS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_if.slave        md,
    output md_state_e      o_dbg_state
);

    localparam int CW = $clog2(STEPS) + 1;

    md_state_e         r_state;
    md_op_e            r_op;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_sreg;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_dividend;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic              r_busy;

    logic              w_is_div;
    logic              w_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN-1:0]   w_acc_nx;
    logic [XLEN-1:0]   w_sreg_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_hi_res;
    logic [XLEN-1:0]   w_lo_res;

    assign w_is_div = op_is_div(r_op);
    assign w_sgn    = ~md.opE[0];
    assign w_a_neg  = w_sgn & md.srca2E[XLEN-1];
    assign w_b_neg  = w_sgn & md.srcb2E[XLEN-1];
    assign w_a_abs  = w_a_neg ? -md.srca2E : md.srca2E;
    assign w_b_abs  = w_b_neg ? -md.srcb2E : md.srcb2E;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_sreg   (r_sreg),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_nx),
        .o_sreg   (w_sreg_nx)
    );

    // Divide leaves the remainder in acc and the quotient in sreg
    assign w_prod     = {r_acc, r_sreg};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_sreg : r_sreg;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;
    assign w_hi_res   = !w_is_div ? w_prod_fix[2*XLEN-1:XLEN] :
                        (r_div0 ? r_dividend : w_rem);
    assign w_lo_res   = !w_is_div ? w_prod_fix[XLEN-1:0] :
                        (r_div0 ? XLEN'(DIV0_LO) : w_quo);

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   w_rem_mask;
    logic [CW:0]       w_shamt;
    logic [2*XLEN-1:0] w_skip;
    logic              w_early;

    // Low XLEN-cnt bits of sreg are the multiplier bits not yet consumed
    assign w_rem_mask = {XLEN{1'b1}} >> r_cnt;
    assign w_early    = !w_is_div && ((r_sreg & w_rem_mask) == '0);
    assign w_shamt    = (CW+1)'(XLEN) - (CW+1)'(r_cnt);
    assign w_skip     = w_prod >> w_shamt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_op       <= MD_MULT;
            r_acc      <= '0;
            r_sreg     <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md.startE) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_op       <= md_op_e'(md.opE);
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_sreg     <= md.opE[1] ? w_a_abs : w_b_abs;
                        r_opnd     <= md.opE[1] ? w_b_abs : w_a_abs;
                        r_dividend <= md.srca2E;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div0     <= (md.srcb2E == '0);
                    end else begin
                        if (md.mthiE) r_hi <= md.srca2E;
                        if (md.mtloE) r_lo <= md.srca2E;
                    end
                end
                RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_early) begin
                        {r_acc, r_sreg} <= w_skip;
                        r_state         <= FIX;
                    end else
`endif
                    begin
                        r_acc  <= w_acc_nx;
                        r_sreg <= w_sreg_nx;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == CW'(STEPS - 1)) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi    <= w_hi_res;
                    r_lo    <= w_lo_res;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign md.busy     = r_busy;
    assign md.done     = (r_state == FIX);
    assign md.stallMD  = md.hiloD & (r_busy | md.startE);
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus hand-written corner sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  md_state_e dbg_state;
  int n_checks = 0;
  int n_fail = 0;

  muldiv_if #(.XLEN(32)) md();

  muldiv_ctrl #(.XLEN(32), .STEPS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .md          (md),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          eo_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    md.startE = 1'b0; md.opE = 2'b00; md.srca2E = '0; md.srcb2E = '0;
    md.mthiE = 1'b0; md.mtloE = 1'b0; md.hiloD = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int done_at, output int ndone);
    @(negedge clk);
    md.opE = op; md.srca2E = a; md.srcb2E = b; md.startE = 1'b1;
    @(negedge clk);
    md.startE = 1'b0;
    nbusy = 0; done_at = -1; ndone = 0;
    while (md.busy && nbusy < 100) begin
      if (md.done) begin
        ndone++;
        done_at = nbusy;
      end
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] v);
    @(negedge clk);
    md.mthiE = hi_en; md.mtloE = lo_en; md.srca2E = v;
    @(negedge clk);
    md.mthiE = 1'b0; md.mtloE = 1'b0;
  endtask

  initial begin
    int nbusy, done_at, ndone, exp_busy, bad_stall;

    vecs[0]  = '{"mult_neg3x5",   MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1]  = '{"multu_fffdx5",  MD_MULTU, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 5};
    vecs[2]  = '{"div_m7_2",      MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{"divu_100_7",    MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4]  = '{"divu_by0",      MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 33};
    vecs[5]  = '{"div_min_m1",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[6]  = '{"mult_7x9",      MD_MULT,  32'd7,         32'd9,         32'd0,         32'd63,        6};
    vecs[7]  = '{"div_7_m2",      MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[8]  = '{"multu_max_sq",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[9]  = '{"div_m7_by0",    MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33};
    vecs[10] = '{"multu_3x2",     MD_MULTU, 32'd3,         32'd2,         32'd0,         32'd6,         4};
    vecs[11] = '{"mult_x0",       MD_MULT,  32'h0001_2345, 32'd0,         32'd0,         32'd0,         2};

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", md.hi, 32'd0);
    check("rst_lo", md.lo, 32'd0);
    check("rst_busy", {31'd0, md.busy}, 32'd0);
    check("rst_done", {31'd0, md.done}, 32'd0);
    check("rst_stall", {31'd0, md.stallMD}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset = 1'b1;

    // table-driven operations
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nbusy, done_at, ndone);
`ifdef MULDIV_EARLY_OUT_EN
      exp_busy = vecs[i].eo_busy;
`else
      exp_busy = 33;
`endif
      check({vecs[i].name, "_hi"}, md.hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, md.lo, vecs[i].lo);
      check({vecs[i].name, "_busy_cycles"}, nbusy, exp_busy);
      check({vecs[i].name, "_done_cycle"}, done_at, exp_busy - 1);
      check({vecs[i].name, "_done_count"}, ndone, 32'd1);
    end

    // separate and simultaneous HI/LO moves in IDLE
    move(1'b1, 1'b0, 32'h0000_AAAA);
    check("mthi_hi", md.hi, 32'h0000_AAAA);
    move(1'b0, 1'b1, 32'h0000_5555);
    check("mtlo_lo", md.lo, 32'h0000_5555);
    check("mtlo_hi_kept", md.hi, 32'h0000_AAAA);
    move(1'b1, 1'b1, 32'h0000_1357);
    check("mthilo_hi", md.hi, 32'h0000_1357);
    check("mthilo_lo", md.lo, 32'h0000_1357);

    // stall window, start-wins-over-move, ignored start/move mid-RUN
    @(negedge clk);
    md.hiloD = 1'b1;
    md.opE = MD_DIVU; md.srca2E = 32'd100; md.srcb2E = 32'd7;
    md.startE = 1'b1; md.mthiE = 1'b1;
    #1 check("stall_on_start", {31'd0, md.stallMD}, 32'd1);
    @(negedge clk);
    md.startE = 1'b0; md.mthiE = 1'b0;
    check("start_beats_mthi", md.hi, 32'h0000_1357);
    nbusy = 0; bad_stall = 0;
    while (md.busy && nbusy < 100) begin
      if (!md.stallMD) bad_stall++;
      if (nbusy == 5) begin
        md.startE = 1'b1; md.opE = MD_MULTU; md.srca2E = 32'h0000_BEEF;
        md.srcb2E = 32'd3; md.mthiE = 1'b1; md.mtloE = 1'b1;
      end
      nbusy++;
      @(negedge clk);
      if (nbusy == 6) begin
        md.startE = 1'b0; md.mthiE = 1'b0; md.mtloE = 1'b0;
        check("midrun_move_hi", md.hi, 32'h0000_1357);
        check("midrun_move_lo", md.lo, 32'h0000_1357);
      end
    end
    check("stall_during_op", bad_stall, 32'd0);
    check("stall_busy_cycles", nbusy, 32'd33);
    check("stall_off_after", {31'd0, md.stallMD}, 32'd0);
    check("midrun_start_hi", md.hi, 32'd2);
    check("midrun_start_lo", md.lo, 32'd14);
    md.hiloD = 1'b0;

    // reset abandons MULT 7x9 at RUN cycle 10
    move(1'b1, 1'b0, 32'h0000_DEAD);
    check("pre_rst_hi", md.hi, 32'h0000_DEAD);
    @(negedge clk);
    md.opE = MD_MULT; md.srca2E = 32'd7; md.srcb2E = 32'd9; md.startE = 1'b1;
    @(negedge clk);
    md.startE = 1'b0;
    repeat (10) @(negedge clk);
`ifndef MULDIV_EARLY_OUT_EN
    check("pre_rst_busy", {31'd0, md.busy}, 32'd1);
`endif
    reset = 1'b0;
    #1;
    check("midrst_hi", md.hi, 32'd0);
    check("midrst_lo", md.lo, 32'd0);
    check("midrst_busy", {31'd0, md.busy}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_hi", md.hi, 32'd0);
    check("post_rst_lo", md.lo, 32'd0);
    check("post_rst_busy", {31'd0, md.busy}, 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
